// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory loader
package imem_loader_pkg;

    localparam int WORD_BYTES = 4;
    localparam int LEN_W      = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [LEN_W-1:0] idx);
        return base + {14'b0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_pack.sv
// imem_loader_pack: assembles little-endian bytes into 32-bit words
module imem_loader_pack
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] sr_q, sr_d;

    always_comb begin
        cnt_d = clr ? 2'd0 : byte_valid ? cnt_q + 2'd1 : cnt_q;
        sr_d  = clr ? 32'd0 : byte_valid ? {byte_data, sr_q[31:8]} : sr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 2'd0;
            sr_q  <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end

    // The completed word is offered combinationally alongside the 4th byte
    assign word       = {byte_data, sr_q[31:8]};
    assign word_valid = byte_valid && (cnt_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed byte image into instruction memory, holding the CPU until done
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam logic [LEN_W:0] DEPTH_L = (LEN_W + 1)'(DEPTH_WORDS);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] idx_q, idx_d, len_q, len_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic             accept, restart, word_valid;
    logic [31:0]      word;
    logic [LEN_W-1:0] len_full, idx_inc;

    assign in_ready = state_q inside {LEN_LO, LEN_HI, DATA};
    assign accept   = in_valid && in_ready;
    assign restart  = start && (state_q inside {IDLE, DONE, ERR});
    assign len_full = {in_data, len_q[7:0]};
    assign idx_inc  = idx_q + 16'd1;

    imem_loader_pack u_pack (
        .clk        (clk),
        .reset      (reset),
        .clr        (restart),
        .byte_valid (accept && state_q == DATA),
        .byte_data  (in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = 32'd0;
        mem_wdata_d = 32'd0;
        case (state_q)
            IDLE, DONE, ERR: if (start) begin
                state_d = LEN_LO;
                idx_d   = '0;
                len_d   = '0;
            end
            LEN_LO: if (accept) begin
                len_d   = {8'h00, in_data};
                state_d = LEN_HI;
            end
            LEN_HI: if (accept) begin
                len_d   = len_full;
                state_d = ({1'b0, len_full} > DEPTH_L) ? ERR : (len_full == '0) ? DONE : DATA;
            end
            // Memory-port registers load here so the strobe lands in the WRITE cycle
            DATA: if (word_valid) begin
                state_d     = WRITE;
                mem_we_d    = 1'b1;
                mem_addr_d  = word_addr(BASE_ADDR, idx_q);
                mem_wdata_d = word;
            end
            WRITE: begin
                idx_d   = idx_inc;
                state_d = (idx_inc == len_q) ? DONE : DATA;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = state_q != DONE;
    assign done      = state_q == DONE;
    assign error     = state_q == ERR;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven and randomized loads checked against a write-list model
module tb_imem_loader;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk, reset, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, mem_we, cpu_hold, done, error;
    logic [31:0] mem_addr, mem_wdata;

    imem_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic [31:0] wq[$];

    typedef struct {
        logic [15:0] n;
        int          gap;
        bit          exp_err;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we) begin
            obs_addr.push_back(mem_addr);
            obs_data.push_back(mem_wdata);
            check("in_ready_during_write", {31'b0, in_ready}, 32'd0);
        end else if (reset) begin
            check("port_zero_when_idle", mem_addr | mem_wdata, 32'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int gap = $urandom_range(0, gap_max);
        int waited = 0;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) begin
                start = ($urandom_range(0, 3) == 0);
                @(negedge clk);
            end
            start = 1'b0;
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            vectors++;
            miscompares++;
            $display("FAIL byte_accept_timeout: in_ready stayed 0 for %0d cycles", waited);
        end
        @(negedge clk);
    endtask

    task automatic run_load(input logic [15:0] n, input int gap_max, input bit exp_err);
        logic [31:0] exp_addr[$];
        logic [31:0] exp_data[$];
        logic [31:0] w;
        if (!exp_err) begin
            while (wq.size() < int'(n)) wq.push_back($urandom);
            for (int i = 0; i < int'(n); i++) begin
                exp_addr.push_back(BASE + 32'(i) * 4);
                exp_data.push_back(wq[i]);
            end
        end
        pulse_start;
        check("hold_after_start", {29'b0, cpu_hold, done, error}, 32'b100);
        obs_addr.delete();
        obs_data.delete();
        send_byte(n[7:0], gap_max);
        send_byte(n[15:8], gap_max);
        if (!exp_err) begin
            for (int i = 0; i < int'(n); i++) begin
                w = wq[i];
                for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap_max);
            end
        end
        in_valid = 1'b0;
        check("hold_after_last_byte", {31'b0, cpu_hold}, {31'b0, !(n == 16'd0)});
        repeat (3) @(negedge clk);
        #1;
        check("write_count", 32'(obs_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            check("write_addr", obs_addr[i], exp_addr[i]);
            check("write_data", obs_data[i], exp_data[i]);
        end
        check("done", {31'b0, done}, {31'b0, !exp_err});
        check("error", {31'b0, error}, {31'b0, exp_err});
        check("cpu_hold_end", {31'b0, cpu_hold}, {31'b0, exp_err});
        check("in_ready_end", {31'b0, in_ready}, 32'd0);
        wq.delete();
    endtask

    initial begin
        logic [15:0] n;
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_addr_data", mem_addr | mem_wdata, 32'd0);
        check("rst_flags", {29'b0, cpu_hold, done, error}, 32'b100);
        reset = 1'b1;
        @(negedge clk);
        check("idle_flags", {28'b0, in_ready, cpu_hold, done, error}, 32'b0100);

        wq = '{32'h0000_0013, 32'h0010_0093};
        run_load(16'd2, 0, 1'b0);

        run_load(16'd257, 0, 1'b1);
        run_load(16'd2, 0, 1'b0);

        tbl[0] = '{16'd1, 0, 1'b0};
        tbl[1] = '{16'd0, 0, 1'b0};
        tbl[2] = '{16'd3, 5, 1'b0};
        tbl[3] = '{16'd256, 0, 1'b0};
        tbl[4] = '{16'hFFFF, 1, 1'b1};
        tbl[5] = '{16'd7, 2, 1'b0};
        tbl[6] = '{16'd258, 3, 1'b1};
        tbl[7] = '{16'd5, 0, 1'b0};
        for (int t = 0; t < 8; t++) run_load(tbl[t].n, tbl[t].gap, tbl[t].exp_err);

        for (int r = 0; r < 8; r++) begin
            n = ($urandom_range(0, 5) == 0) ? 16'(256 + $urandom_range(1, 500)) : 16'($urandom_range(0, 12));
            run_load(n, $urandom_range(0, 4), n > 16'(DEPTH));
        end

        pulse_start;
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int k = 0; k < 6; k++) send_byte(8'(k + 1), 0);
        in_valid = 1'b0;
        obs_addr.delete();
        obs_data.delete();
        reset = 1'b0;
        #1;
        check("midrst_mem_we", {31'b0, mem_we}, 32'd0);
        check("midrst_addr_data", mem_addr | mem_wdata, 32'd0);
        check("midrst_flags", {28'b0, in_ready, cpu_hold, done, error}, 32'b0100);
        repeat (3) @(negedge clk);
        check("midrst_no_write", 32'(obs_addr.size()), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {28'b0, in_ready, cpu_hold, done, error}, 32'b0100);
        run_load(16'd1, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
